// File: rtl/npn_canon_pkg.sv
//==============================================================================
// Module   : npn_canon_pkg
// Purpose  : Shared FSM state encodings, factorial helper and transform record
//            for the sequential NPN canonicaliser.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package npn_canon_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SEARCH = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // Largest supported function arity and the matching permutation-entry width
    localparam int c_MAX_VARS   = 5;
    localparam int c_MAX_PIDX_W = 3;
    localparam int c_XF_PERM_W  = c_MAX_VARS * c_MAX_PIDX_W;

    // n! - used both for the search bound and for Lehmer digit radices
    function automatic int unsigned factorial(input int unsigned n);
        int unsigned f;
        f = 1;
        for (int unsigned i = 2; i <= n; i++) begin
            f = f * i;
        end
        return f;
    endfunction

    // NPN transform; the perm field holds packed entries at the instance's
    // PIDX_W stride, upper (unused) bits are zero.
    typedef struct packed {
        logic [c_XF_PERM_W-1:0] perm;
        logic [c_MAX_VARS-1:0]  neg_mask;
        logic                   neg_out;
    } npn_xform_t;

endpackage

`default_nettype wire

// File: rtl/npn_perm_decode.sv
//==============================================================================
// Module   : npn_perm_decode
// Purpose  : Combinational Lehmer-code decoder. Maps a permutation index to the
//            permutation at that rank in lexicographic order (index 0 is the
//            identity). Entry j of o_perm occupies bits [j*PIDX_W +: PIDX_W].
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module npn_perm_decode
    import npn_canon_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int PIDX_W   = 2,
    parameter int IDX_W    = 5
) (
    input  logic [IDX_W-1:0]           i_perm_idx,
    output logic [NUM_VARS*PIDX_W-1:0] o_perm
);

    // Peel factorial-base digits MSB first; each digit selects the n-th
    // still-unused element, which yields lexicographic ordering.
    always_comb begin
        int unsigned          rem;
        int unsigned          digit;
        int unsigned          cnt;
        logic [NUM_VARS-1:0]  used;

        o_perm = '0;
        used   = '0;
        rem    = 32'(i_perm_idx);
        digit  = 0;
        cnt    = 0;
        for (int i = 0; i < NUM_VARS; i++) begin
            digit = rem / factorial(NUM_VARS - 1 - i);
            rem   = rem % factorial(NUM_VARS - 1 - i);
            cnt   = 0;
            for (int k = 0; k < NUM_VARS; k++) begin
                if (!used[k]) begin
                    if (cnt == digit) begin
                        o_perm[i*PIDX_W +: PIDX_W] = PIDX_W'(k);
                        used[k]                    = 1'b1;
                    end
                    cnt = cnt + 1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/npn_canon_seq.sv
//==============================================================================
// Module   : npn_canon_seq
// Purpose  : Sequential NPN canonicaliser. Walks every (permutation, input
//            negation mask) pair, one pair per cycle, scoring both output
//            phases, and returns the minimum truth table with its transform.
//            Optional build macro NPN_CANON_EARLY_EXIT_EN stops the search as
//            soon as an all-zero candidate has been found.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module npn_canon_seq
    import npn_canon_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int TT_W     = 2**NUM_VARS,
    parameter int PIDX_W   = ($clog2(NUM_VARS) < 1) ? 1 : $clog2(NUM_VARS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TT_W-1:0]            in_tt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TT_W-1:0]            out_tt,
    output logic [NUM_VARS*PIDX_W-1:0] out_perm,
    output logic [NUM_VARS-1:0]        out_neg_mask,
    output logic                       out_neg_out,
    output logic                       busy
);

    localparam int c_PERM_W      = NUM_VARS * PIDX_W;
    localparam int c_NUM_PERMS   = int'(factorial(NUM_VARS));
    localparam int c_PIDX_CNT_W  = (c_NUM_PERMS > 1) ? $clog2(c_NUM_PERMS) : 1;
    localparam logic [c_PIDX_CNT_W-1:0] c_LAST_PERM = c_PIDX_CNT_W'(c_NUM_PERMS - 1);
    localparam logic [NUM_VARS-1:0]     c_LAST_MASK = '1;

    logic [1:0]              r_state;
    logic [TT_W-1:0]         r_tt;
    logic [c_PIDX_CNT_W-1:0] r_perm_idx;
    logic [NUM_VARS-1:0]     r_mask;
    logic [TT_W-1:0]         r_best_tt;
    npn_xform_t              r_best_xf;
    logic [TT_W-1:0]         r_out_tt;
    npn_xform_t              r_out_xf;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_out_valid;

    logic [c_PERM_W-1:0]     w_perm;
    logic [TT_W-1:0]         w_cand0;
    logic [TT_W-1:0]         w_cand1;
    npn_xform_t              w_cur_xf;
    logic [TT_W-1:0]         w_ph0_tt;
    npn_xform_t              w_ph0_xf;
    logic [TT_W-1:0]         w_nxt_tt;
    npn_xform_t              w_nxt_xf;
    logic                    w_last_pair;
    logic                    w_search_end;
    logic                    w_unused_xf;

    npn_perm_decode #(
        .NUM_VARS (NUM_VARS),
        .PIDX_W   (PIDX_W),
        .IDX_W    (c_PIDX_CNT_W)
    ) u_perm_decode (
        .i_perm_idx (r_perm_idx),
        .o_perm     (w_perm)
    );

    // Phase-0 candidate: one bit per minterm, looked up through the permuted,
    // negated input address.
    for (genvar m = 0; m < TT_W; m++) begin : g_mint
        localparam logic [NUM_VARS-1:0] c_M = NUM_VARS'(m);
        logic [NUM_VARS-1:0] w_y;

        // Scatter the (negated) minterm bits to their permuted positions
        always_comb begin
            w_y = '0;
            for (int j = 0; j < NUM_VARS; j++) begin
                w_y[w_perm[j*PIDX_W +: PIDX_W]] = c_M[j] ^ r_mask[j];
            end
        end

        assign w_cand0[m] = r_tt[w_y];
    end

    assign w_cand1 = ~w_cand0;

    // Transform describing the pair under evaluation (phase 0)
    always_comb begin
        w_cur_xf          = '0;
        w_cur_xf.perm     = c_XF_PERM_W'(w_perm);
        w_cur_xf.neg_mask = c_MAX_VARS'(r_mask);
        w_cur_xf.neg_out  = 1'b0;
    end

    // Strict-less compare chain: phase 0 against best, phase 1 against the
    // phase-0 winner, so ties always keep the earlier candidate.
    always_comb begin
        w_ph0_tt = r_best_tt;
        w_ph0_xf = r_best_xf;
        if (w_cand0 < r_best_tt) begin
            w_ph0_tt = w_cand0;
            w_ph0_xf = w_cur_xf;
        end
        w_nxt_tt = w_ph0_tt;
        w_nxt_xf = w_ph0_xf;
        if (w_cand1 < w_ph0_tt) begin
            w_nxt_tt         = w_cand1;
            w_nxt_xf         = w_cur_xf;
            w_nxt_xf.neg_out = 1'b1;
        end
    end

    assign w_last_pair = (r_perm_idx == c_LAST_PERM) && (r_mask == c_LAST_MASK);

`ifdef NPN_CANON_EARLY_EXIT_EN
    // Zero cannot be beaten, so the search may stop at the first one found
    assign w_search_end = w_last_pair || (w_nxt_tt == '0);
`else
    assign w_search_end = w_last_pair;
`endif

    // Control FSM plus search and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_tt        <= '0;
            r_perm_idx  <= '0;
            r_mask      <= '0;
            r_best_tt   <= '1;
            r_best_xf   <= '0;
            r_out_tt    <= '0;
            r_out_xf    <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_tt       <= in_tt;
                        r_perm_idx <= '0;
                        r_mask     <= '0;
                        r_best_tt  <= '1;
                        r_best_xf  <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_SEARCH;
                    end
                end
                c_ST_SEARCH: begin
                    r_best_tt <= w_nxt_tt;
                    r_best_xf <= w_nxt_xf;
                    if (w_search_end) begin
                        r_out_tt    <= w_nxt_tt;
                        r_out_xf    <= w_nxt_xf;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_mask <= r_mask + 1'b1;
                        if (r_mask == c_LAST_MASK) begin
                            r_perm_idx <= r_perm_idx + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign out_valid    = r_out_valid;
    assign out_tt       = r_out_tt;
    assign out_perm     = r_out_xf.perm[c_PERM_W-1:0];
    assign out_neg_mask = r_out_xf.neg_mask[NUM_VARS-1:0];
    assign out_neg_out  = r_out_xf.neg_out;

    // Spare high bits of the max-width transform record are never consumed
    assign w_unused_xf  = ^r_out_xf;

endmodule

`default_nettype wire
